sram_burst_master: RTL and testbench
====================================

Name: sram_burst_master

Overview:
- Initiator for the single-port synchronous SRAM macro model: clk-sampled read_en/write_en/addr/data_in, 1-cycle registered data_out.
- Accepts one burst command at a time: write N words from a valid/ready stream, or read N words into a valid/ready stream.
- Hides the SRAM's 1-cycle read latency behind a 2-entry output FIFO, so downstream backpressure never drops data.
- Sits between PE-array buffer managers and each on-chip SRAM bank.

Parameters:
- SRAM_DEPTH_BIT, 10, SRAM address width. Depth = 2**SRAM_DEPTH_BIT.
- SRAM_WIDTH, 64, data word width.
- LEN_BIT, 10, width of burst length field.

Ports:
- clk  in  1  clock, all flops posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  SRAM_DEPTH_BIT  start word address.
- cmd_len  in  LEN_BIT  words minus one (0 means 1 word).
- wr_valid  in  1  write data offered.
- wr_ready  out  1  write data accepted.
- wr_data  in  SRAM_WIDTH  write word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer takes word.
- rd_data  out  SRAM_WIDTH  read word (FIFO head).
- busy  out  1  state != IDLE.
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- sram_read_en  out  1  to SRAM read_en.
- sram_write_en  out  1  to SRAM write_en.
- sram_addr  out  SRAM_DEPTH_BIT  to SRAM addr.
- sram_data_in  out  SRAM_WIDTH  to SRAM data_in.
- sram_data_out  in  SRAM_WIDTH  from SRAM, valid the cycle after sram_read_en.

Behaviour:
- Reset (async, rst_n=0): state IDLE, cur_addr=0, remaining=0, FIFO empty, inflight=0.
  - All outputs 0: rd_valid, busy, cmd_err, sram_read_en, sram_write_en, sram_addr, wr_ready.
  - cmd_ready goes 1 from the first cycle after rst_n deasserts.
  - Reset mid-burst aborts the burst; FIFO contents are discarded.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept: load cur_addr=cmd_addr, remaining=cmd_len.
  - Next state is WRITE or READ from cmd_wr, or stays IDLE with cmd_err pulse (see Optional Feature).
- WRITE:
  - wr_ready=1.
  - sram_write_en = wr_valid (combinational).
  - sram_addr = cur_addr, sram_data_in = wr_data.
  - Each handshake: cur_addr+1, remaining-1.
  - Handshake with remaining==0 -> IDLE next cycle.
  - wr_valid low stalls with no SRAM access.
  - sram_read_en=0 in WRITE.
- READ:
  - sram_read_en = (fifo_cnt + inflight - pop) < 2, where pop = rd_valid&rd_ready.
  - sram_addr = cur_addr.
  - inflight register = sram_read_en of the previous cycle.
  - Returned sram_data_out is pushed into the FIFO the cycle after issue.
  - Sustains 1 word/cycle when rd_ready is held high.
  - Issue with remaining==0 -> DRAIN.
- DRAIN:
  - No SRAM access.
  - -> IDLE when inflight==0 and the FIFO is empty, or becomes empty this cycle.
- FIFO:
  - 2 entries, rd_valid = fifo_cnt != 0.
  - Simultaneous push and pop keeps the count; push and pop in the same cycle with count 0 is impossible (rd_valid is 0).
  - The credit rule guarantees no overflow; overflow is an assertion failure.
- Address arithmetic is modulo 2**SRAM_DEPTH_BIT.
- sram_write_en and sram_read_en are never both 1.
- Read-after-write on the same address across consecutive commands returns the new data (write completes at the clock edge before the read is issued).

Optional Feature:
- Macro: SRAM_ADDR_WRAP_EN.
- Defined: any command is accepted; address wraps from depth-1 to 0.
- Undefined:
  - A command with cmd_addr + cmd_len > 2**SRAM_DEPTH_BIT - 1 is still handshaken (cmd_ready=1).
  - It is discarded: cmd_err pulses for 1 cycle, state stays IDLE, no SRAM access.

Decomposition:
- Shared package sram_pkg: state enum (IDLE/WRITE/READ/DRAIN), default widths SRAM_DEPTH_BIT/SRAM_WIDTH/LEN_BIT.
- One sub-module: sram_rd_fifo2 (2-entry FIFO: push, pop, count, head data).
- FSM, counters and credit logic stay in the top module.

Test Plan:
- Write burst: addr=0x010, len=3, data A0..A3 with wr_valid held high.
  -> 4 consecutive cycles of sram_write_en=1, addrs 0x010..0x013; busy drops on the 5th cycle.
- Read burst: addr=0x010, len=3, rd_ready=1.
  -> rd_data A0..A3 on 4 consecutive cycles, first rd_valid 2 cycles after cmd accept; then IDLE.
- Read backpressure: len=7, rd_ready toggled 1-0-0-1 pattern.
  -> never more than 2 reads outstanding plus buffered, no loss or duplication, order preserved.
- Write stall: wr_valid low for 3 cycles mid-burst.
  -> no sram_write_en in those cycles; address resumes at the next word.
- Boundary: addr=0x3FE, len=3.
  -> with SRAM_ADDR_WRAP_EN: accesses 0x3FE, 0x3FF, 0x000, 0x001.
  -> without it: cmd_err=1 for one cycle, no SRAM access, cmd_ready=1 next cycle.
- Reset mid-read: assert rst_n=0 after 2 words issued.
  -> rd_valid=0, busy=0 immediately; after release a new write command is accepted normally.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and default widths for the SRAM burst master and its read FIFO.
package sram_pkg;

    localparam int SRAM_DEPTH_BIT_DEF = 10;
    localparam int SRAM_WIDTH_DEF     = 64;
    localparam int LEN_BIT_DEF        = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Width helper used to size the end-address comparison.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_rd_fifo2.sv
// Two-entry FIFO that absorbs SRAM read returns while the consumer stalls.
// Only pointers and occupancy are reset; the storage words are not.
module sram_rd_fifo2
    import sram_pkg::*;
#(
    parameter int WIDTH = SRAM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; data words carry no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    // The master's credit rule must never let the FIFO overflow or underflow.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == 2'd2));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == 2'd0));

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for a single-port synchronous SRAM (1-cycle read latency).
// Runs one write or read burst at a time; read returns are buffered in a
// 2-entry FIFO so consumer backpressure never loses a word.
// Build option: define SRAM_ADDR_WRAP_EN to let bursts wrap past the top
// address; otherwise a burst that would cross it is handshaken and dropped
// with a one-cycle cmd_err pulse.
module sram_burst_master
    import sram_pkg::*;
#(
    parameter int SRAM_DEPTH_BIT = SRAM_DEPTH_BIT_DEF,
    parameter int SRAM_WIDTH     = SRAM_WIDTH_DEF,
    parameter int LEN_BIT        = LEN_BIT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [SRAM_DEPTH_BIT-1:0] cmd_addr,
    input  logic [LEN_BIT-1:0]        cmd_len,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [SRAM_WIDTH-1:0]     wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [SRAM_WIDTH-1:0]     rd_data,
    output logic                      busy,
    output logic                      cmd_err,
    output logic                      sram_read_en,
    output logic                      sram_write_en,
    output logic [SRAM_DEPTH_BIT-1:0] sram_addr,
    output logic [SRAM_WIDTH-1:0]     sram_data_in,
    input  logic [SRAM_WIDTH-1:0]     sram_data_out
);

    localparam int SUM_W = max_int(SRAM_DEPTH_BIT, LEN_BIT) + 1;

    state_t                    state;
    state_t                    state_nxt;
    logic [SRAM_DEPTH_BIT-1:0] cur_addr;
    logic [LEN_BIT-1:0]        remaining;
    logic                      inflight;
    logic                      started;
    logic                      cmd_err_q;
    logic [1:0]                fifo_cnt;
    logic                      pop;
    logic                      cmd_fire;
    logic                      cmd_bad;
    logic                      wr_fire;
    logic                      rd_issue;
    logic [2:0]                credit_use;

`ifdef SRAM_ADDR_WRAP_EN
    assign cmd_bad = 1'b0;
`else
    logic [SUM_W-1:0] end_addr;
    assign end_addr = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign cmd_bad  = end_addr > SUM_W'({SRAM_DEPTH_BIT{1'b1}});
`endif

    assign rd_valid   = (fifo_cnt != 2'd0);
    assign pop        = rd_valid & rd_ready;
    // Words buffered plus the one possibly in flight, net of this cycle's pop.
    assign credit_use = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign busy       = (state != IDLE);
    assign cmd_err    = cmd_err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and SRAM/handshake outputs.
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        cmd_fire      = 1'b0;
        wr_ready      = 1'b0;
        wr_fire       = 1'b0;
        rd_issue      = 1'b0;
        sram_write_en = 1'b0;
        sram_read_en  = 1'b0;
        sram_addr     = '0;
        sram_data_in  = '0;
        case (state)
            IDLE: begin
                cmd_ready = started;
                cmd_fire  = cmd_valid & started;
                if (cmd_fire && !cmd_bad) state_nxt = cmd_wr ? WRITE : READ;
            end
            WRITE: begin
                wr_ready      = 1'b1;
                wr_fire       = wr_valid;
                sram_write_en = wr_valid;
                sram_addr     = cur_addr;
                sram_data_in  = wr_data;
                if (wr_fire && remaining == '0) state_nxt = IDLE;
            end
            READ: begin
                rd_issue     = (credit_use < 3'd2);
                sram_read_en = rd_issue;
                sram_addr    = cur_addr;
                if (rd_issue && remaining == '0) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!inflight && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop)))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst address/length counters, read-in-flight flag and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            started   <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            started   <= 1'b1;
            inflight  <= rd_issue;
            cmd_err_q <= cmd_fire & cmd_bad;
            if (cmd_fire) begin
                cur_addr  <= cmd_addr;
                remaining <= cmd_len;
            end else if (wr_fire || rd_issue) begin
                cur_addr  <= cur_addr + SRAM_DEPTH_BIT'(1);
                remaining <= remaining - LEN_BIT'(1);
            end
        end
    end

    sram_rd_fifo2 #(
        .WIDTH(SRAM_WIDTH)
    ) u_rd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_data(sram_data_out),
        .pop      (pop),
        .count    (fifo_cnt),
        .head     (rd_data)
    );

endmodule

// File: tb/tb_sram_burst_master.sv
// Self-checking bench for sram_burst_master: SRAM macro model, shadow-memory
// reference, table-driven bursts, directed corner cases and random bursts.
`timescale 1ns/1ps
module tb_sram_burst_master;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int LW    = 10;
    localparam int DEPTH = 1 << AW;
`ifdef SRAM_ADDR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          cmd_err;
    logic          sram_read_en;
    logic          sram_write_en;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data_in;
    logic [DW-1:0] sram_data_out = '0;

    sram_burst_master #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .LEN_BIT(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .cmd_err(cmd_err),
        .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
        .sram_addr(sram_addr), .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
    );

    always #5 clk = ~clk;

    // SRAM macro model plus access logs.
    int            cyc = 0;
    int            n_issue = 0;
    logic [DW-1:0] mem [DEPTH];
    int            wr_log_addr[$];
    int            wr_log_cyc[$];
    int            rd_log_addr[$];
    int            rd_log_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_write_en) begin
            mem[sram_addr] <= sram_data_in;
            wr_log_addr.push_back(int'(sram_addr));
            wr_log_cyc.push_back(cyc);
        end
        if (sram_read_en) begin
            sram_data_out <= mem[sram_addr];
            rd_log_addr.push_back(int'(sram_addr));
            rd_log_cyc.push_back(cyc);
            n_issue <= n_issue + 1;
        end
    end

    int   excl_bad = 0;
    logic prev_busy = 1'b0;
    int   busy_fall_cyc = -1;
    always @(negedge clk) begin
        if (sram_read_en && sram_write_en) excl_bad++;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: shadow memory updated per completed write burst.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wbuf [DEPTH];
    logic [DW-1:0] got[$];
    int n_checks = 0;
    int n_fail = 0;
    int acc_cyc, first_cyc, last_cyc, max_occ, last_w0, last_r0;

    function automatic logic [AW-1:0] wrap_addr(input int a, input int i);
        return AW'((a + i) % DEPTH);
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input int a, input int l);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = AW'(a); cmd_len = LW'(l);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        acc_cyc = cyc;
        check_eq("cmd_accept", ok, 1);
    endtask

    task automatic write_words(input int n, input int pct, input int stall_at, input int stall_len);
        int i = 0;
        int c = 0;
        int st = 0;
        bit hs;
        while (i < n && c < 5000) begin
            if (i == stall_at && st < stall_len) begin
                wr_valid = 1'b0; st++;
            end else if ($urandom_range(0, 99) >= pct) begin
                wr_valid = 1'b0;
            end else begin
                wr_valid = 1'b1; wr_data = wbuf[AW'(i)];
            end
            @(negedge clk);
            hs = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (hs) i++;
            c++;
        end
        wr_valid = 1'b0;
        check_eq("wr_words_taken", i, n);
    endtask

    task automatic read_words(input int n, input int mode);
        int c = 0;
        int iss0 = n_issue;
        int occ;
        got.delete(); max_occ = 0; first_cyc = -1; last_cyc = -1;
        while (got.size() < n && c < 5000) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (c % 4 == 0) || (c % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            occ = (n_issue - iss0) - got.size();
            if (occ > max_occ) max_occ = occ;
            if (rd_valid && rd_ready) begin
                got.push_back(rd_data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            @(posedge clk); #1;
            c++;
        end
        rd_ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        @(negedge clk);
        while (busy && c < 3000) begin @(negedge clk); c++; end
        check_eq({name, ":idle"}, busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input string name, input logic wr, input int a, input int l,
                           input int mode, input int pct, input int stall_at,
                           input bit exp_err, input int exp_n);
        int w0 = wr_log_addr.size();
        int r0 = rd_log_addr.size();
        int nacc, nother, nbad;
        last_w0 = w0; last_r0 = r0;
        if (wr) for (int i = 0; i <= l; i++) wbuf[AW'(i)] = {$urandom, $urandom};
        send_cmd(wr, a, l);
        if (exp_err) begin
            @(negedge clk);
            check_eq({name, ":cmd_err_pulse"}, cmd_err, 1);
            check_eq({name, ":busy_on_err"}, busy, 0);
            @(negedge clk);
            check_eq({name, ":cmd_err_clear"}, cmd_err, 0);
            check_eq({name, ":cmd_ready_after_err"}, cmd_ready, 1);
            repeat (3) @(negedge clk);
            @(posedge clk); #1;
        end else if (wr) begin
            write_words(l + 1, pct, stall_at, 3);
            for (int i = 0; i <= l; i++) ref_mem[wrap_addr(a, i)] = wbuf[AW'(i)];
            wait_idle(name);
        end else begin
            read_words(l + 1, mode);
            check_eq({name, ":rd_count"}, got.size(), l + 1);
            nbad = 0;
            foreach (got[i]) begin
                if (got[i] !== ref_mem[wrap_addr(a, i)]) begin
                    if (nbad == 0)
                        $display("  %s word %0d: got %h exp %h", name, i, got[i], ref_mem[wrap_addr(a, i)]);
                    nbad++;
                end
            end
            check_eq({name, ":rd_data_bad_words"}, nbad, 0);
            wait_idle(name);
            check_eq({name, ":no_extra_rd_valid"}, rd_valid, 0);
        end
        nacc   = wr ? wr_log_addr.size() - w0 : rd_log_addr.size() - r0;
        nother = wr ? rd_log_addr.size() - r0 : wr_log_addr.size() - w0;
        check_eq({name, ":access_count"}, nacc, exp_n);
        check_eq({name, ":no_cross_access"}, nother, 0);
        nbad = 0;
        for (int i = 0; i < nacc; i++) begin
            if ((wr ? wr_log_addr[w0 + i] : rd_log_addr[r0 + i]) != int'(wrap_addr(a, i))) nbad++;
        end
        check_eq({name, ":addr_sequence_bad"}, nbad, 0);
    endtask

    typedef struct {
        logic wr;
        int   addr;
        int   len;
        int   mode;
        bit   exp_err;
        int   exp_n;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int   c;
        logic r_wr;
        int   r_len, r_addr;
        bit   r_bad;

        tbl[0] = '{1'b1, 'h010, 3,     0, 1'b0,  4};
        tbl[1] = '{1'b0, 'h010, 3,     0, 1'b0,  4};
        tbl[2] = '{1'b1, 'h3FE, 3,     0, !WRAP, WRAP ? 4 : 0};
        tbl[3] = '{1'b0, 'h3FE, 3,     0, !WRAP, WRAP ? 4 : 0};
        tbl[4] = '{1'b1, 'h3FF, 0,     0, 1'b0,  1};
        tbl[5] = '{1'b0, 'h3FF, 0,     1, 1'b0,  1};
        tbl[6] = '{1'b0, 'h3F0, 15,    2, 1'b0,  16};
        tbl[7] = '{1'b1, 'h200, 'h3FF, 0, !WRAP, WRAP ? 1024 : 0};
        tbl[8] = '{1'b0, 'h001, 'h3FE, 0, 1'b0,  1023};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst:rd_valid", rd_valid, 0);
        check_eq("rst:busy", busy, 0);
        check_eq("rst:cmd_err", cmd_err, 0);
        check_eq("rst:sram_read_en", sram_read_en, 0);
        check_eq("rst:sram_write_en", sram_write_en, 0);
        check_eq("rst:sram_addr", sram_addr, 0);
        check_eq("rst:wr_ready", wr_ready, 0);
        check_eq("rst:cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst:cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // Fill the whole SRAM so every later read has a known value.
        run_cmd("fill", 1'b1, 0, DEPTH - 1, 0, 100, -1, 1'b0, DEPTH);

        // Write burst timing: four back-to-back writes, busy low on the fifth cycle.
        run_cmd("dir_wr", 1'b1, 'h010, 3, 0, 100, -1, 1'b0, 4);
        check_eq("dir_wr:consecutive", wr_log_cyc[last_w0 + 3] - wr_log_cyc[last_w0], 3);
        check_eq("dir_wr:busy_fall", busy_fall_cyc, wr_log_cyc[last_w0] + 4);

        // Read burst timing: first word two cycles after accept, then one per cycle.
        run_cmd("dir_rd", 1'b0, 'h010, 3, 0, 100, -1, 1'b0, 4);
        check_eq("dir_rd:first_latency", first_cyc - acc_cyc, 2);
        check_eq("dir_rd:consecutive", last_cyc - first_cyc, 3);
        check_eq("dir_rd:busy_fall", busy_fall_cyc, last_cyc + 1);

        // Read with 1-0-0-1 consumer backpressure.
        run_cmd("bp_rd", 1'b0, 'h020, 7, 1, 100, -1, 1'b0, 8);
        check_eq("bp_rd:max_outstanding_le2", (max_occ <= 2), 1);

        // Write burst with a three-cycle wr_valid gap before the third word.
        run_cmd("stall_wr", 1'b1, 'h030, 5, 0, 100, 2, 1'b0, 6);
        check_eq("stall_wr:first_pair", wr_log_cyc[last_w0 + 1] - wr_log_cyc[last_w0], 1);
        check_eq("stall_wr:gap", wr_log_cyc[last_w0 + 2] - wr_log_cyc[last_w0 + 1], 4);
        run_cmd("stall_rd", 1'b0, 'h030, 5, 0, 100, -1, 1'b0, 6);

        // Table of bursts, including boundary and full-depth cases.
        foreach (tbl[i])
            run_cmd($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].len,
                    tbl[i].mode, 100, -1, tbl[i].exp_err, tbl[i].exp_n);

        // Reset in the middle of a read burst after two words were issued.
        last_r0 = rd_log_addr.size();
        send_cmd(1'b0, 'h040, 7);
        c = 0;
        while (rd_log_addr.size() - last_r0 < 2 && c < 50) begin @(negedge clk); c++; end
        check_eq("mid_rst:two_issued", rd_log_addr.size() - last_r0, 2);
        check_eq("mid_rst:rd_valid_before", rd_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst:rd_valid", rd_valid, 0);
        check_eq("mid_rst:busy", busy, 0);
        check_eq("mid_rst:sram_read_en", sram_read_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_cmd("mid_rst_wr", 1'b1, 'h040, 1, 0, 100, -1, 1'b0, 2);
        run_cmd("mid_rst_rd", 1'b0, 'h040, 1, 0, 100, -1, 1'b0, 2);

        // Random bursts against the shadow-memory model.
        for (int t = 0; t < 25; t++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_len  = $urandom_range(0, 15);
            r_addr = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - int'($urandom_range(0, 12))
                                                 : int'($urandom_range(0, DEPTH - 1));
            r_bad  = !WRAP && (r_addr + r_len > DEPTH - 1);
            run_cmd($sformatf("rand%0d", t), r_wr, r_addr, r_len, 2, 70, -1,
                    r_bad, r_bad ? 0 : r_len + 1);
        end

        check_eq("no_read_write_overlap", excl_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
